// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module : bp_pkg
// Brief  : 2-bit saturating branch counter encodings and update helper.
// Rev    : 1.0  initial release
// ============================================================================
package bp_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t STRONG_NT = 2'b00;
  localparam ctr_t WEAK_NT   = 2'b01;
  localparam ctr_t WEAK_T    = 2'b10;
  localparam ctr_t STRONG_T  = 2'b11;

  // Saturating step toward the resolved direction; never wraps.
  function automatic ctr_t sat_update(input ctr_t c, input logic taken);
    ctr_t r;
    r = c;
    if (taken) begin
      if (c != STRONG_T) r = c + 2'd1;
    end else begin
      if (c != STRONG_NT) r = c - 2'd1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pht_upd_fifo.sv
`default_nettype none
// ============================================================================
// Module : pht_upd_fifo
// Brief  : Synchronous FIFO buffering PHT updates {idx, taken}.
// Rev    : 1.0  initial release
// ============================================================================
module pht_upd_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_wr;
  logic             w_rd;

  assign full    = (r_count == CNT_W'(DEPTH));
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign rd_data = r_mem[r_rd_ptr];

  // Full blocks writes on the registered count, even if a read frees a slot.
  assign w_wr = wr_en && !full;
  assign w_rd = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/pht_access_scheduler.sv
`default_nettype none
// ============================================================================
// Module : pht_access_scheduler
// Brief  : PHT owner arbitrating one access slot between lookups and queued
//          updates, with forced drains to bound update starvation.
// Rev    : 1.0  initial release
// ============================================================================
module pht_access_scheduler
  import bp_pkg::*;
#(
  parameter int IDX_W      = 4,
  parameter int UQ_DEPTH   = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        lk_valid,
  input  logic [IDX_W-1:0]            lk_idx,
  output logic                        lk_ready,
  output logic                        pred_valid,
  output logic                        pred_taken,
  input  logic                        upd_valid,
  input  logic [IDX_W-1:0]            upd_idx,
  input  logic                        upd_taken,
  output logic                        upd_ready,
  output logic [$clog2(UQ_DEPTH):0]   uq_count
);

  localparam int ENTRIES = 2 ** IDX_W;
  localparam int SC_W    = $clog2(STARVE_MAX + 1);

  ctr_t             r_pht [ENTRIES];
  logic [SC_W-1:0]  r_starve_cnt;
  logic             r_pred_valid;
  logic             r_pred_taken;

  logic             w_uq_full;
  logic             w_uq_empty;
  logic [IDX_W:0]   w_head;
  logic [IDX_W-1:0] w_head_idx;
  logic             w_head_taken;
  logic             w_force_drain;
  logic             w_lk_grant;
  logic             w_deq;
  logic             w_enq;

  assign w_head_idx   = w_head[IDX_W:1];
  assign w_head_taken = w_head[0];

  assign w_force_drain = (r_starve_cnt == SC_W'(STARVE_MAX)) && !w_uq_empty;
  assign lk_ready      = !w_force_drain;
  assign upd_ready     = !w_uq_full;

  // Lookups win the slot unless a drain is forced; the queue head gets leftovers.
  assign w_lk_grant = lk_valid && lk_ready;
  assign w_deq      = !w_lk_grant && !w_uq_empty;
  assign w_enq      = upd_valid && upd_ready;

  pht_upd_fifo #(
    .WIDTH (IDX_W + 1),
    .DEPTH (UQ_DEPTH)
  ) u_upd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_enq),
    .wr_data ({upd_idx, upd_taken}),
    .rd_en   (w_deq),
    .rd_data (w_head),
    .count   (uq_count),
    .full    (w_uq_full),
    .empty   (w_uq_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (w_uq_empty || w_deq) begin
      r_starve_cnt <= '0;
    end else if (w_lk_grant && (r_starve_cnt != SC_W'(STARVE_MAX))) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) r_pht[i] <= WEAK_NT;
    end else if (w_deq) begin
      r_pht[w_head_idx] <= sat_update(r_pht[w_head_idx], w_head_taken);
    end
  end

  // Reads see only committed counters; queued updates are not forwarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pred_valid <= 1'b0;
      r_pred_taken <= 1'b0;
    end else begin
      r_pred_valid <= w_lk_grant;
      if (w_lk_grant) r_pred_taken <= r_pht[lk_idx][1];
    end
  end

  assign pred_valid = r_pred_valid;
  assign pred_taken = r_pred_taken;

endmodule
`default_nettype wire

// File: doc/pht_access_scheduler.md
Name: pht_access_scheduler

Overview:
- Owns a pattern history table (PHT) of 2-bit saturating branch counters and controls all access to it.
- Arbitrates the table's single access slot per cycle between fetch-side prediction lookups and execute-side resolution updates.
- Buffers updates in a small queue and forces update drains so that updates are never starved.
- Sits between the fetch stage (lookups) and the branch-resolve stage (updates).

Parameters:
- IDX_W, 4, PHT index width; the table has 2**IDX_W entries.
- UQ_DEPTH, 4, update queue depth; must be a power of two and at least 2.
- STARVE_MAX, 8, maximum number of consecutive lookup grants allowed while the update queue is non-empty.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- lk_valid  in  1  lookup request.
- lk_idx  in  IDX_W  lookup index.
- lk_ready  out  1  lookup accepted this cycle when lk_valid and lk_ready are both high.
- pred_valid  out  1  prediction valid, registered.
- pred_taken  out  1  predicted direction, registered.
- upd_valid  in  1  update request.
- upd_idx  in  IDX_W  update index.
- upd_taken  in  1  resolved outcome of the branch.
- upd_ready  out  1  update enqueued this cycle when upd_valid and upd_ready are both high.
- uq_count  out  clog2(UQ_DEPTH)+1  current update queue occupancy.

Behaviour:
- Reset is asynchronous and active-low:
  - all counters go to WEAKLY_NOT_TAKEN (2'b01);
  - the queue is emptied and uq_count=0;
  - starve_cnt=0;
  - pred_valid=0, pred_taken=0.
  - While rst_n is low, lk_ready=1 and upd_ready=1 (combinational outputs, shown for completeness; no handshake completes while in reset).
  - Assertion mid-operation discards queued updates and any in-flight prediction in the same instant.
- Counter encoding:
  - 00 = strongly not-taken, 01 = weakly not-taken, 10 = weakly taken, 11 = strongly taken.
  - Prediction is counter[1].
  - Update rule: taken gives min(c+1, 3); not-taken gives max(c-1, 0). Both saturate and never wrap.
- One table access per cycle, either a lookup read or an update write from the queue head.
- Arbitration:
  - force_drain = (starve_cnt == STARVE_MAX) and queue non-empty.
  - lk_ready = !force_drain (combinational).
  - A lookup is granted when lk_valid && lk_ready.
  - Otherwise, if the queue is non-empty, the head update is applied to the table and dequeued.
  - Only when neither a lookup is granted nor the queue is non-empty is the slot idle.
- starve_cnt:
  - increments on each lookup grant while the queue is non-empty;
  - clears on any dequeue and whenever the queue is empty;
  - saturates at STARVE_MAX.
- Lookup latency is 1 cycle:
  - pred_valid is high the cycle after a grant; pred_taken is the counter MSB read at grant time.
  - pred_valid is 0 in cycles after no grant; pred_taken holds its last value.
- Lookups read the committed table only. There is no forwarding from queued updates; staleness is permitted.
- Update queue:
  - FIFO order.
  - upd_ready = (uq_count != UQ_DEPTH), derived from the registered count only.
  - Simultaneous enqueue and dequeue leaves the count unchanged. When full, enqueue is blocked even if a dequeue occurs that cycle.
  - Pointers wrap modulo UQ_DEPTH.
- A write and a read of the same index can never occur in one cycle, because there is a single slot.
- A dequeued update is visible to a lookup granted in the next cycle.

Decomposition:
- Package bp_pkg:
  - counter encodings STRONG_NT=2'b00, WEAK_NT=2'b01, WEAK_T=2'b10, STRONG_T=2'b11;
  - typedef ctr_t (2-bit);
  - function sat_update(ctr_t, taken) returning ctr_t.
- Sub-module pht_upd_fifo: synchronous FIFO carrying {idx, taken}, parameterised by width and depth, with async active-low reset, count output, full and empty flags.
- Arbitration, the starvation counter and the table stay in the top level.

Test Plan:
- Reset, then lookup idx 3 -> pred_valid=1 one cycle later with pred_taken=0; uq_count=0; lk_ready=1.
- Enqueue update idx 5 taken twice with no lookups, then lookup idx 5 -> counter 01->10->11, pred_taken=1; lookup idx 6 gives pred_taken=0.
- Hold lk_valid=1 every cycle with one queued update, STARVE_MAX=8 -> 8 lookup grants, then lk_ready=0 for exactly 1 cycle, the update is applied, starve_cnt clears and lk_ready returns to 1.
- Enqueue 4 updates while lookups are continuously granted -> uq_count=4, upd_ready=0; a 5th update is held until the forced dequeue, and upd_ready rises the cycle after the count drops.
- Saturation: 5 not-taken updates to idx 0, then 5 taken updates -> counter floors at 00 and ceilings at 11, with no wrap; final lookup gives pred_taken=1.
- Assert rst_n low mid-stream with 3 queued updates and pred_valid=1 -> pred_valid=0 and uq_count=0 immediately; after release, idx 5 reads pred_taken=0 (counter 01).
